// File: rtl/mbist_sched_pkg.sv
// Shared types and default sizing for the MBIST scheduler.
package mbist_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_SHIFT,
    ST_LOAD,
    ST_RUN,
    ST_CAPT,
    ST_FIN
  } sched_st_t;

  localparam int unsigned DEF_NUM_MEM = 4;
  localparam int unsigned DEF_CFG_WD  = 32;
  localparam int unsigned DEF_TMO_WD  = 20;

endpackage

// File: rtl/mbist_sched_pick.sv
// Priority finder: lowest set mask bit at or above a start index (cur, or cur+1).
module mbist_sched_pick
  import mbist_sched_pkg::*;
#(
  parameter int unsigned NUM_MEM = DEF_NUM_MEM
) (
  input  logic [NUM_MEM-1:0] mask,
  input  logic [3:0]         cur,
  input  logic               incl,
  output logic [3:0]         idx,
  output logic               found
);

  logic [4:0] lo;

  always_comb begin
    lo    = incl ? {1'b0, cur} : {1'b0, cur} + 5'd1;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_MEM; i++) begin
      if (!found && mask[i] && (5'(i) >= lo)) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbist_sched.sv
// Sequences NUM_MEM MBIST instances: shift config, load, run, capture, per selected memory.
// Optional run watchdog and timeout port under `define MBIST_SCHED_TIMEOUT_EN.
module mbist_sched
  import mbist_sched_pkg::*;
#(
  parameter int unsigned NUM_MEM = DEF_NUM_MEM,
  parameter int unsigned CFG_WD  = DEF_CFG_WD,
  parameter int unsigned TMO_WD  = DEF_TMO_WD
) (
  input  logic               bist_clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_MEM-1:0] mem_mask,
  input  logic [CFG_WD-1:0]  cfg_data,
  output logic               busy,
  output logic               done,
  output logic [NUM_MEM-1:0] fail,
  output logic [NUM_MEM-1:0] tested,
`ifdef MBIST_SCHED_TIMEOUT_EN
  output logic [NUM_MEM-1:0] timeout,
`endif
  output logic [NUM_MEM-1:0] bist_en,
  output logic [NUM_MEM-1:0] bist_shift,
  output logic [NUM_MEM-1:0] bist_load,
  output logic [NUM_MEM-1:0] bist_run,
  output logic               bist_sdi,
  input  logic [NUM_MEM-1:0] bist_done,
  input  logic [NUM_MEM-1:0] bist_error
);

  localparam int unsigned CNT_WD = $clog2(CFG_WD);

  sched_st_t          state, state_nxt;
  logic [3:0]         cur, cur_nxt;
  logic               incl;
  logic [NUM_MEM-1:0] mask_q, cur_oh, nxt_oh;
  logic [CFG_WD-1:0]  shreg, shreg_rot;
  logic [CNT_WD-1:0]  shcnt;
  logic [3:0]         pick_idx;
  logic               pick_found;
  logic               start_acc, run_done, tmo_hit;

  assign start_acc = (state == ST_IDLE) && start;
  assign cur_oh    = NUM_MEM'(1) << cur;
  assign nxt_oh    = NUM_MEM'(1) << cur_nxt;
  assign run_done  = |(bist_done & cur_oh);
  assign shreg_rot = {shreg[0], shreg[CFG_WD-1:1]};

  mbist_sched_pick #(.NUM_MEM(NUM_MEM)) u_pick (
    .mask  (mask_q),
    .cur   (cur),
    .incl  (incl),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge bist_clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    case (state)
      ST_IDLE:  if (start) begin
                  state_nxt = ST_SEL;
                  cur_nxt   = '0;
                end
      ST_SEL:   if (pick_found) begin
                  state_nxt = ST_SHIFT;
                  cur_nxt   = pick_idx;
                end else begin
                  state_nxt = ST_FIN;
                end
      ST_SHIFT: if (shcnt == CNT_WD'(CFG_WD - 1)) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_RUN;
      ST_RUN:   if (run_done || tmo_hit) state_nxt = ST_CAPT;
      ST_CAPT:  state_nxt = ST_SEL;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from next-state so every output changes on the edge.
  always_ff @(posedge bist_clk) begin
    if (rst) begin
      incl       <= 1'b0;
      mask_q     <= '0;
      shreg      <= '0;
      shcnt      <= '0;
      fail       <= '0;
      tested     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bist_en    <= '0;
      bist_shift <= '0;
      bist_load  <= '0;
      bist_run   <= '0;
      bist_sdi   <= 1'b0;
    end else begin
      if (start_acc) begin
        incl   <= 1'b1;
        mask_q <= mem_mask;
        shreg  <= cfg_data;
      end else begin
        if (state == ST_SHIFT) begin
          incl  <= 1'b0;
          shreg <= shreg_rot;
        end
      end
      shcnt <= (state == ST_SHIFT) ? shcnt + CNT_WD'(1) : '0;

      if (start_acc) begin
        fail   <= '0;
        tested <= '0;
      end else begin
        if (state == ST_RUN && run_done) fail <= fail | (bist_error & cur_oh);
        else if (tmo_hit)                fail <= fail | cur_oh;
        if (state == ST_CAPT)            tested <= tested | cur_oh;
      end

      busy       <= (state_nxt != ST_IDLE) && (state_nxt != ST_FIN);
      done       <= (state_nxt == ST_FIN);
      bist_en    <= (state_nxt inside {ST_SHIFT, ST_LOAD, ST_RUN, ST_CAPT}) ? nxt_oh : '0;
      bist_shift <= (state_nxt == ST_SHIFT) ? nxt_oh : '0;
      bist_load  <= (state_nxt == ST_LOAD)  ? nxt_oh : '0;
      bist_run   <= (state_nxt == ST_RUN)   ? nxt_oh : '0;
      // shreg rotates at the same edge, so look one bit ahead while already shifting.
      bist_sdi   <= (state_nxt == ST_SHIFT) && ((state == ST_SHIFT) ? shreg_rot[0] : shreg[0]);
    end
  end

`ifdef MBIST_SCHED_TIMEOUT_EN
  logic [TMO_WD-1:0] tmo_cnt;

  assign tmo_hit = (state == ST_RUN) && !run_done &&
                   ((tmo_cnt + TMO_WD'(1)) == {TMO_WD{1'b1}});

  always_ff @(posedge bist_clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      timeout <= '0;
    end else begin
      tmo_cnt <= (state == ST_RUN) ? tmo_cnt + TMO_WD'(1) : '0;
      if (start_acc)    timeout <= '0;
      else if (tmo_hit) timeout <= timeout | cur_oh;
    end
  end
`else
  logic [TMO_WD-1:0] tmo_unused;
  assign tmo_unused = '0;
  assign tmo_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_mbist_sched.sv
// Directed self-checking bench for mbist_sched with a behavioural MBIST instance model.
module tb_mbist_sched;

  localparam int NM = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NM-1:0] mem_mask = '0;
  logic [CW-1:0] cfg_data = '0;
  logic          busy, done, bist_sdi;
  logic [NM-1:0] fail, tested, bist_en, bist_shift, bist_load, bist_run;
  logic [NM-1:0] bist_done = '0;
  logic [NM-1:0] bist_error = '0;
`ifdef MBIST_SCHED_TIMEOUT_EN
  logic [NM-1:0] timeout;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   run_len [NM];
  logic err_val [NM];
  int   run_cnt [NM];

  mbist_sched #(.NUM_MEM(NM), .CFG_WD(CW), .TMO_WD(4)) dut (
    .bist_clk   (clk),
    .rst        (rst),
    .start      (start),
    .mem_mask   (mem_mask),
    .cfg_data   (cfg_data),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .tested     (tested),
`ifdef MBIST_SCHED_TIMEOUT_EN
    .timeout    (timeout),
`endif
    .bist_en    (bist_en),
    .bist_shift (bist_shift),
    .bist_load  (bist_load),
    .bist_run   (bist_run),
    .bist_sdi   (bist_sdi),
    .bist_done  (bist_done),
    .bist_error (bist_error)
  );

  always #5 clk = ~clk;

  // Instance model: done/error rise after run_len cycles of run (0 = never).
  always @(negedge clk) begin
    for (int i = 0; i < NM; i++) begin
      if (bist_run[i]) begin
        run_cnt[i]++;
        if (run_len[i] != 0 && run_cnt[i] >= run_len[i]) begin
          bist_done[i]  = 1'b1;
          bist_error[i] = err_val[i];
        end
      end else begin
        run_cnt[i]    = 0;
        bist_done[i]  = 1'b0;
        bist_error[i] = 1'b0;
      end
    end
  end

  task automatic setup_mems(input int l0, l1, l2, l3, input logic [NM-1:0] errs);
    run_len[0] = l0; run_len[1] = l1; run_len[2] = l2; run_len[3] = l3;
    for (int i = 0; i < NM; i++) err_val[i] = errs[i];
  endtask

  task automatic launch(input logic [NM-1:0] m, input logic [CW-1:0] c);
    @(negedge clk);
    start    = 1'b1;
    mem_mask = m;
    cfg_data = c;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, fail, tested, bist_en, bist_shift, bist_load, bist_run, bist_sdi} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b fail=%b tested=%b en=%b sh=%b ld=%b run=%b sdi=%b, want all 0",
               busy, done, fail, tested, bist_en, bist_shift, bist_load, bist_run, bist_sdi);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_mem;
    logic [63:0]   stream = '0;
    logic [63:0]   want;
    logic [NM-1:0] loads [4];
    logic [NM-1:0] shifts_seen = '0;
    int nbits = 0, nld = 0, done_c = -1, bad_oh = 0;
    logic [CW-1:0] cfg = 32'hA5A5_0F0F;
    want = {cfg, cfg};
    setup_mems(50, 0, 50, 0, 4'b0000);
    launch(4'b0101, cfg);
    for (int c = 1; c <= 400 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL two_mem_busy: got %b want 1", busy); end
      end
      if (!$onehot0(bist_en) || (bist_shift & ~bist_en) != 0 || (bist_run & ~bist_en) != 0) bad_oh++;
      shifts_seen |= bist_shift;
      if (bist_shift != 0 && nbits < 64) begin stream[nbits] = bist_sdi; nbits++; end
      if (bist_load != 0) begin if (nld < 4) loads[nld] = bist_load; nld++; end
      if (done) done_c = c;
    end
    n_checks++;
    if (done_c !== 172) begin n_fail++; $display("FAIL two_mem_done_cycle: got %0d want 172", done_c); end
    n_checks++;
    if (nbits !== 64 || stream !== want) begin
      n_fail++; $display("FAIL two_mem_sdi: got %0d bits %h want 64 bits %h", nbits, stream, want);
    end
    n_checks++;
    if (nld !== 2 || loads[0] !== 4'b0001 || loads[1] !== 4'b0100) begin
      n_fail++; $display("FAIL two_mem_loads: got n=%0d %b,%b want 2 0001,0100", nld, loads[0], loads[1]);
    end
    n_checks++;
    if (shifts_seen !== 4'b0101) begin n_fail++; $display("FAIL two_mem_shift_sel: got %b want 0101", shifts_seen); end
    n_checks++;
    if (bad_oh !== 0) begin n_fail++; $display("FAIL two_mem_onehot: got %0d bad cycles want 0", bad_oh); end
    n_checks++;
    if (tested !== 4'b0101 || fail !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL two_mem_result: got tested=%b fail=%b busy=%b want 0101 0000 0", tested, fail, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL two_mem_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_error;
    int done_c = -1;
    setup_mems(0, 10, 0, 0, 4'b0010);
    launch(4'b0010, 32'h1234_5678);
    for (int c = 1; c <= 200 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) done_c = c;
    end
    n_checks++;
    if (done_c !== 47) begin n_fail++; $display("FAIL error_done_cycle: got %0d want 47", done_c); end
    n_checks++;
    if (fail !== 4'b0010 || tested !== 4'b0010) begin
      n_fail++; $display("FAIL error_flags: got fail=%b tested=%b want 0010 0010", fail, tested);
    end
  endtask

  task automatic test_empty_mask;
    int done_c = -1, activity = 0;
    launch(4'b0000, 32'hFFFF_FFFF);
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if ({bist_en, bist_shift, bist_load, bist_run, bist_sdi} != 0) activity++;
      if (done) done_c = c;
    end
    n_checks++;
    if (done_c !== 2) begin n_fail++; $display("FAIL empty_done_cycle: got %0d want 2", done_c); end
    n_checks++;
    if (activity !== 0 || fail !== 4'b0000 || tested !== 4'b0000) begin
      n_fail++; $display("FAIL empty_quiet: got activity=%0d fail=%b tested=%b want 0 0000 0000", activity, fail, tested);
    end
  endtask

  task automatic test_start_while_busy;
    int done_c = -1, poke = 0;
    setup_mems(20, 0, 0, 0, 4'b0000);
    launch(4'b0001, 32'h0000_0001);
    for (int c = 1; c <= 200 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (poke == 1) begin
        start = 1'b0;
        mem_mask = 4'b0001;
        poke = 2;
        n_checks++;
        if (tested !== 4'b0000 || fail !== 4'b0000 || busy !== 1'b1) begin
          n_fail++; $display("FAIL busy_start_flags: got tested=%b fail=%b busy=%b want 0000 0000 1", tested, fail, busy);
        end
      end
      if (poke == 0 && bist_run != 0) begin start = 1'b1; mem_mask = 4'b1111; poke = 1; end
      if (done) done_c = c;
    end
    n_checks++;
    if (done_c !== 57 || tested !== 4'b0001) begin
      n_fail++; $display("FAIL busy_start_ignored: got done@%0d tested=%b want 57 0001", done_c, tested);
    end
  endtask

  task automatic test_reset_in_shift;
    int done_c = -1;
    setup_mems(5, 0, 0, 0, 4'b0000);
    launch(4'b0001, 32'hDEAD_BEEF);
    for (int c = 1; c <= 10 && bist_shift == 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, fail, tested, bist_en, bist_shift, bist_load, bist_run, bist_sdi} !== '0) begin
      n_fail++;
      $display("FAIL shift_reset_outputs: got busy=%b done=%b en=%b sh=%b sdi=%b, want all 0",
               busy, done, bist_en, bist_shift, bist_sdi);
    end
    rst = 1'b0;
    launch(4'b0001, 32'hDEAD_BEEF);
    for (int c = 1; c <= 100 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) done_c = c;
    end
    n_checks++;
    if (done_c !== 42 || tested !== 4'b0001 || fail !== 4'b0000) begin
      n_fail++; $display("FAIL shift_reset_restart: got done@%0d tested=%b fail=%b want 42 0001 0000", done_c, tested, fail);
    end
  endtask

`ifdef MBIST_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int done_c = -1, run0 = 0;
    setup_mems(0, 3, 0, 0, 4'b0000);
    launch(4'b0011, 32'h0F0F_F0F0);
    for (int c = 1; c <= 300 && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (bist_run[0]) run0++;
      if (done) done_c = c;
    end
    n_checks++;
    if (run0 !== 15) begin n_fail++; $display("FAIL timeout_run_len: got %0d want 15", run0); end
    n_checks++;
    if (done_c !== 90) begin n_fail++; $display("FAIL timeout_done_cycle: got %0d want 90", done_c); end
    n_checks++;
    if (timeout !== 4'b0001 || fail !== 4'b0001 || tested !== 4'b0011) begin
      n_fail++; $display("FAIL timeout_flags: got tmo=%b fail=%b tested=%b want 0001 0001 0011", timeout, fail, tested);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NM; i++) begin run_len[i] = 0; err_val[i] = 1'b0; run_cnt[i] = 0; end
    test_reset();
    test_two_mem();
    test_error();
    test_empty_mask();
    test_start_while_busy();
    test_reset_in_shift();
`ifdef MBIST_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
